// File: rtl/crc5_pkg.sv
// Shared CRC-5 constants and checker state encoding.
// The transmitter imports the same constants, so both ends of the link agree.
package crc5_pkg;

   localparam int               CRC_W    = 5;
   localparam logic [CRC_W-1:0] CRC_POLY = 5'h05;
   localparam logic [CRC_W-1:0] CRC_INIT = 5'h00;

   // Fixed encodings so netlists and older tooling see stable state values
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BODY   = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      BODY   = ST_BODY,
      REPORT = ST_REPORT
   } state_e;

endpackage

// File: rtl/crc5_checker_if.sv
// Byte stream into the CRC-5 checker: valid/ready handshake plus data and end-of-frame marker.
// The master drives bytes, the slave (checker) returns ready.
interface crc5_checker_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output in_ready
   );

endinterface

// File: rtl/crc5_update.sv
// One-byte CRC-5 fold (x^5+x^2+1, MSB first), purely combinational.
// Shared with the transmitter so both ends use bit-identical math.
module crc5_update
   import crc5_pkg::*;
(
   input  logic [CRC_W-1:0] crc_in,
   input  logic [7:0]       data,
   output logic [CRC_W-1:0] crc_out
);

   logic [CRC_W-1:0] w_crc;

   always_comb begin
      w_crc = crc_in;
      for (int i = 7; i >= 0; i--) begin
         if (w_crc[CRC_W-1] ^ data[i]) begin
            w_crc = {w_crc[CRC_W-2:0], 1'b0} ^ CRC_POLY;
         end else begin
            w_crc = {w_crc[CRC_W-2:0], 1'b0};
         end
      end
   end

   assign crc_out = w_crc;

endmodule

// File: rtl/crc5_checker.sv
// Receive-side CRC-5 checker: payload bytes then a trailer whose [4:0] holds the CRC.
// Define CRC5_ERR_CNT_EN to build the saturating failed-frame counter on err_cnt.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for the first beat of a frame (may be the trailer)
// BODY   | folding payload bytes; overflow freezes the CRC until in_last
// REPORT | bubble cycle, done=1, results valid, frame state cleared
module crc5_checker
   import crc5_pkg::*;
#(
   parameter int MAX_LEN = 64,
   parameter int CNT_W   = 8
) (
   input  logic             ck,
   input  logic             rst_n,
   crc5_checker_if.slave    s_in,
   output logic             done,
   output logic             crc_ok,
   output logic [CRC_W-1:0] crc_calc,
   output logic             len_err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   state_e           r_state;
   state_e           w_state_next;
   logic [CRC_W-1:0] r_crc;
   logic [LEN_W-1:0] r_len;
   logic             r_ovf;
   logic             r_ready;
   logic             r_crc_ok;
   logic [CRC_W-1:0] r_crc_calc;
   logic             r_len_err;

   logic             w_xfer;
   logic             w_end;
   logic             w_at_max;
   logic             w_pass;
   logic [CRC_W-1:0] w_crc_base;
   logic [CRC_W-1:0] w_crc_next;

   assign w_xfer     = s_in.in_valid && r_ready;
   assign w_end      = w_xfer && s_in.in_last;
   assign w_at_max   = (r_len == LEN_W'(MAX_LEN));
   // The first beat always folds from the init value, whatever r_crc holds
   assign w_crc_base = (r_state == BODY) ? r_crc : CRC_INIT;
   assign w_pass     = !r_ovf && (s_in.in_data[CRC_W-1:0] == w_crc_base);

   crc5_update u_update (
      .crc_in  (w_crc_base),
      .data    (s_in.in_data),
      .crc_out (w_crc_next)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_xfer) w_state_next = s_in.in_last ? REPORT : BODY;
         BODY:    if (w_end)  w_state_next = REPORT;
         REPORT:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_crc      <= CRC_INIT;
         r_len      <= '0;
         r_ovf      <= 1'b0;
         r_ready    <= 1'b0;
         r_crc_ok   <= 1'b0;
         r_crc_calc <= '0;
         r_len_err  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ready <= (w_state_next != REPORT);

         if (r_state == REPORT) begin
            r_crc <= CRC_INIT;
            r_len <= '0;
            r_ovf <= 1'b0;
         end else if (w_xfer && !s_in.in_last) begin
            if (r_state == IDLE) begin
               r_crc <= w_crc_next;
               r_len <= LEN_W'(1);
            end else if (r_ovf || w_at_max) begin
               r_ovf <= 1'b1;
            end else begin
               r_crc <= w_crc_next;
               r_len <= r_len + LEN_W'(1);
            end
         end

         // Results load with the trailer so they are already valid while done is high
         if (w_end) begin
            r_crc_ok   <= w_pass;
            r_crc_calc <= w_crc_base;
            r_len_err  <= r_ovf;
         end
      end
   end

`ifdef CRC5_ERR_CNT_EN
   logic [CNT_W-1:0] r_err_cnt;

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if (w_end && !w_pass && (r_err_cnt != {CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = '0;
`endif

   assign s_in.in_ready = r_ready;
   assign done          = (r_state == REPORT);
   assign crc_ok        = r_crc_ok;
   assign crc_calc      = r_crc_calc;
   assign len_err       = r_len_err;

endmodule
